ascon_spi_bridge: RTL and testbench

SPI slave front-end that sits directly upstream of ascon_core and replaces the file-driven test bench in hardware. It receives 32-bit instruction and data words over SPI and decodes the instructions. It drives the core's key/bdi streams and the decrypt/hash mode signals. Core output (bdo words, auth result) is buffered in a small FIFO and returned to the host on MISO.

---
 rtl/ascon_spi_bridge.sv | 273 +++++++++++++++++++++++++++
 tb/tb_ascon_spi_bridge.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_spi_bridge.sv
// SPI slave front-end for ascon_core: decodes 32-bit instruction/data words from the host,
// streams key/bdi words into the core and returns bdo/auth words on MISO through a small FIFO.
//
// state | meaning
// S_INS | next received word is an instruction
// S_DAT | next received word is segment data (remaining words still to hand over)
module ascon_spi_bridge #(
    parameter int OFIFO_DEPTH = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CCW         = 32,
    parameter int CCSW        = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            spi_sclk,
    input  logic            spi_cs_n,
    input  logic            spi_mosi,
    output logic            spi_miso,
    output logic [CCSW-1:0] key,
    output logic            key_valid,
    input  logic            key_ready,
    output logic [CCW-1:0]  bdi,
    output logic            bdi_valid,
    input  logic            bdi_ready,
    output logic [3:0]      bdi_type,
    output logic            bdi_eot,
    output logic            bdi_eoi,
    output logic            decrypt,
    output logic            hash,
    input  logic [CCW-1:0]  bdo,
    input  logic            bdo_valid,
    output logic            bdo_ready,
    input  logic [3:0]      bdo_type,
    input  logic            bdo_eot,
    input  logic            auth,
    input  logic            auth_valid,
    output logic            auth_ready,
    output logic            ovf
);

    localparam logic [3:0] OP_DO_ENC   = 4'h0;
    localparam logic [3:0] OP_DO_DEC   = 4'h1;
    localparam logic [3:0] OP_DO_HASH  = 4'h2;
    localparam logic [3:0] OP_LD_KEY   = 4'h3;
    localparam logic [3:0] OP_LD_NONCE = 4'h4;
    localparam logic [3:0] OP_LD_AD    = 4'h5;
    localparam logic [3:0] OP_LD_PT    = 4'h6;
    localparam logic [3:0] OP_LD_CT    = 4'h7;
    localparam logic [3:0] OP_LD_TAG   = 4'h8;

    localparam logic [3:0] D_NULL  = 4'h0;
    localparam logic [3:0] D_NONCE = 4'h1;
    localparam logic [3:0] D_AD    = 4'h2;
    localparam logic [3:0] D_PTCT  = 4'h3;
    localparam logic [3:0] D_TAG   = 4'h4;

    localparam int AW = $clog2(OFIFO_DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(OFIFO_DEPTH);

    typedef enum logic {S_INS = 1'b0, S_DAT = 1'b1} state_t;

    // ---------------- input synchronisers and edge detection ----------------
    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic sclk_d, cs_d;
    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d & ~cs_s;
    assign sclk_fall = ~sclk_s & sclk_d & ~cs_s;
    assign cs_fall   = ~cs_s & cs_d;

    // ---------------- receive shifter ----------------
    logic [30:0] rx_sr;
    logic [4:0]  bit_cnt;
    logic [31:0] rx_word;
    logic        rx_strobe;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sr     <= '0;
            bit_cnt   <= '0;
            rx_word   <= '0;
            rx_strobe <= 1'b0;
        end else begin
            rx_strobe <= 1'b0;
            if (cs_s) begin
                bit_cnt <= '0;
            end else if (sclk_rise) begin
                rx_sr   <= {rx_sr[29:0], mosi_s};
                bit_cnt <= bit_cnt + 5'd1;
                if (bit_cnt == 5'd31) begin
                    rx_word   <= {rx_sr, mosi_s};
                    rx_strobe <= 1'b1;
                end
            end
        end
    end

    // ---------------- output FIFO ----------------
    logic [31:0] mem [OFIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic fifo_full, fifo_empty, bdo_push, auth_push, fifo_push, fifo_pop, tx_reload;
    logic [31:0] fifo_din;

    assign fifo_full  = (count == DEPTH_CNT);
    assign fifo_empty = (count == '0);
    assign bdo_ready  = ~fifo_full;
    assign auth_ready = ~fifo_full & ~bdo_valid;
    assign bdo_push   = bdo_valid & bdo_ready;
    assign auth_push  = auth_valid & auth_ready;
    assign fifo_push  = bdo_push | auth_push;
    assign fifo_din   = bdo_push ? bdo : {31'b0, auth};
    assign tx_reload  = cs_fall | rx_strobe;
    assign fifo_pop   = tx_reload & ~fifo_empty;

    always_ff @(posedge clk) begin
        if (fifo_push)
            mem[wr_ptr] <= fifo_din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (fifo_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (fifo_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (fifo_push & ~fifo_pop)
                count <= count + 1'b1;
            else if (fifo_pop & ~fifo_push)
                count <= count - 1'b1;
        end
    end

    // ---------------- transmit shifter ----------------
    // A word-boundary reload lands before the falling edge that closes that word's last bit;
    // that one falling edge must not shift, or the new MSB would never reach the host.
    logic [31:0] tx_sr;
    logic        tx_skip;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_sr   <= '0;
            tx_skip <= 1'b0;
        end else if (tx_reload) begin
            tx_sr   <= fifo_empty ? 32'h0 : mem[rd_ptr];
            tx_skip <= rx_strobe;
        end else if (sclk_fall) begin
            if (tx_skip)
                tx_skip <= 1'b0;
            else
                tx_sr <= {tx_sr[30:0], 1'b0};
        end
    end

    assign spi_miso = tx_sr[31];

    // ---------------- instruction / data FSM ----------------
    state_t state, state_next;
    logic [3:0]  op_r, rx_op, seg_type;
    logic        seg_last, hold_v, is_key, hs, last_hs, ins_strobe, dat_strobe, rx_is_load;
    logic [21:0] remaining, rx_words;
    logic [24:0] len_plus;
    logic [31:0] hold;

    assign is_key   = (op_r == OP_LD_KEY);
    assign rx_op    = rx_word[31:28];
    assign len_plus = {1'b0, rx_word[23:0]} + 25'd3;
    assign rx_words = len_plus[23:2];

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_INS;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        hs         = hold_v & (is_key ? key_ready : bdi_ready);
        last_hs    = hs & (remaining == 22'd1);
        // a word arriving as the final data word is accepted is already the next instruction
        ins_strobe = rx_strobe & ((state == S_INS) | last_hs);
        dat_strobe = rx_strobe & (state == S_DAT) & ~last_hs;
        rx_is_load = (rx_op >= OP_LD_KEY) && (rx_op <= OP_LD_TAG);
        if ((state == S_DAT) && last_hs)
            state_next = S_INS;
        if (ins_strobe && rx_is_load && (rx_words != 22'd0))
            state_next = S_DAT;
        case (op_r)
            OP_LD_NONCE:         seg_type = D_NONCE;
            OP_LD_AD:            seg_type = D_AD;
            OP_LD_PT, OP_LD_CT:  seg_type = D_PTCT;
            OP_LD_TAG:           seg_type = D_TAG;
            default:             seg_type = D_NULL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_r      <= OP_DO_ENC;
            seg_last  <= 1'b0;
            remaining <= '0;
            hold      <= '0;
            hold_v    <= 1'b0;
            decrypt   <= 1'b0;
            hash      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (hs) begin
                hold_v    <= 1'b0;
                remaining <= remaining - 22'd1;
            end
            if (dat_strobe) begin
                if (hold_v & ~hs) begin
                    ovf <= 1'b1;
                end else begin
                    hold   <= rx_word;
                    hold_v <= 1'b1;
                end
            end
            if (ins_strobe) begin
                case (rx_op)
                    OP_DO_ENC:  begin decrypt <= 1'b0; hash <= 1'b0; end
                    OP_DO_DEC:  begin decrypt <= 1'b1; hash <= 1'b0; end
                    OP_DO_HASH: begin decrypt <= 1'b0; hash <= 1'b1; end
                    default: begin
                        if (rx_is_load) begin
                            op_r      <= rx_op;
                            seg_last  <= rx_word[24];
                            remaining <= rx_words;
                        end
                    end
                endcase
            end
        end
    end

    assign key_valid = hold_v & is_key;
    assign bdi_valid = hold_v & ~is_key;
    assign key       = key_valid ? hold[CCSW-1:0] : '0;
    assign bdi       = bdi_valid ? hold[CCW-1:0] : '0;
    assign bdi_type  = bdi_valid ? seg_type : D_NULL;
    assign bdi_eot   = bdi_valid & (remaining == 22'd1);
    assign bdi_eoi   = bdi_eot & seg_last;

    logic unused_bits;
    assign unused_bits = ^{bdo_type, bdo_eot, rx_word[27:25], len_plus[24], len_plus[1:0]};

endmodule

// File: tb/tb_ascon_spi_bridge.sv
// Self-checking bench for ascon_spi_bridge: SPI host model, core-side stream monitor and
// queue-based reference model of the decoded segments and the readback FIFO.
module tb_ascon_spi_bridge;

    localparam logic [3:0] OP_DO_ENC   = 4'h0;
    localparam logic [3:0] OP_DO_DEC   = 4'h1;
    localparam logic [3:0] OP_DO_HASH  = 4'h2;
    localparam logic [3:0] OP_LD_KEY   = 4'h3;
    localparam logic [3:0] OP_LD_NONCE = 4'h4;
    localparam logic [3:0] OP_LD_AD    = 4'h5;
    localparam logic [3:0] OP_LD_PT    = 4'h6;
    localparam logic [3:0] OP_LD_CT    = 4'h7;
    localparam logic [3:0] OP_LD_TAG   = 4'h8;
    localparam logic [3:0] D_NULL  = 4'h0;
    localparam logic [3:0] D_NONCE = 4'h1;
    localparam logic [3:0] D_AD    = 4'h2;
    localparam logic [3:0] D_PTCT  = 4'h3;
    localparam logic [3:0] D_TAG   = 4'h4;

    logic clk = 1'b0, rst = 1'b1;
    logic spi_sclk = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
    logic spi_miso;
    logic [31:0] key, bdi, bdo = '0;
    logic key_valid, bdi_valid, bdi_eot, bdi_eoi, decrypt, hash, bdo_ready, auth_ready, ovf;
    logic [3:0] bdi_type;
    logic key_ready = 1'b1, bdi_ready = 1'b1, bdo_valid = 1'b0, bdo_eot = 1'b0;
    logic auth = 1'b0, auth_valid = 1'b0;
    logic [3:0] bdo_type = 4'h0;

    ascon_spi_bridge #(.OFIFO_DEPTH(4), .SYNC_STAGES(2), .CCW(32), .CCSW(32)) dut (
        .clk(clk), .rst(rst),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .key(key), .key_valid(key_valid), .key_ready(key_ready),
        .bdi(bdi), .bdi_valid(bdi_valid), .bdi_ready(bdi_ready), .bdi_type(bdi_type),
        .bdi_eot(bdi_eot), .bdi_eoi(bdi_eoi), .decrypt(decrypt), .hash(hash),
        .bdo(bdo), .bdo_valid(bdo_valid), .bdo_ready(bdo_ready), .bdo_type(bdo_type),
        .bdo_eot(bdo_eot), .auth(auth), .auth_valid(auth_valid), .auth_ready(auth_ready),
        .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  typ;
        logic        eot;
        logic        eoi;
    } bdi_rec_t;

    typedef struct {
        logic [31:0] ins;
        logic        exp_dec;
        logic        exp_hash;
        int          exp_words;
    } vec_t;

    int n_checks = 0;
    int n_fail = 0;
    bdi_rec_t got_bdi[$], exp_bdi[$];
    logic [31:0] got_key[$], exp_key[$], exp_fifo[$];
    logic model_dec = 1'b0, model_hash = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bdi_valid && bdi_ready)
                got_bdi.push_back('{bdi, bdi_type, bdi_eot, bdi_eoi});
            if (key_valid && key_ready)
                got_key.push_back(key);
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [3:0] type_of(input logic [3:0] op);
        case (op)
            OP_LD_NONCE:        return D_NONCE;
            OP_LD_AD:           return D_AD;
            OP_LD_PT, OP_LD_CT: return D_PTCT;
            OP_LD_TAG:          return D_TAG;
            default:            return D_NULL;
        endcase
    endfunction

    task automatic spi_begin();
        @(posedge clk);
        #2 spi_cs_n = 1'b0;
        #80;
    endtask

    task automatic spi_bits(input logic [31:0] w, input int nbits, output logic [31:0] r);
        r = '0;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = w[31-i];
            #40 spi_sclk = 1'b1;
            r = {r[30:0], spi_miso};
            #40 spi_sclk = 1'b0;
        end
    endtask

    task automatic spi_end();
        #40 spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        #120;
    endtask

    task automatic send_word(input logic [31:0] w);
        logic [31:0] r;
        spi_begin();
        spi_bits(w, 32, r);
        spi_end();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_dec = 1'b0;
        model_hash = 1'b0;
        exp_fifo.delete();
    endtask

    task automatic run_do(input logic [3:0] op);
        send_word({op, 28'h0});
        if (op == OP_DO_ENC) begin model_dec = 1'b0; model_hash = 1'b0; end
        if (op == OP_DO_DEC) begin model_dec = 1'b1; model_hash = 1'b0; end
        if (op == OP_DO_HASH) begin model_dec = 1'b0; model_hash = 1'b1; end
    endtask

    task automatic run_load(input logic [3:0] op, input logic [3:0] flags, input logic [23:0] len);
        int words;
        logic [31:0] w;
        words = (int'(len) + 3) / 4;
        send_word({op, flags, len});
        for (int i = 0; i < words; i++) begin
            w = $urandom;
            if (op == OP_LD_KEY)
                exp_key.push_back(w);
            else
                exp_bdi.push_back('{w, type_of(op), i == words - 1, (i == words - 1) && flags[0]});
            send_word(w);
        end
    endtask

    task automatic check_streams(input string name);
        chk({name, " bdi count"}, 64'(got_bdi.size()), 64'(exp_bdi.size()));
        for (int i = 0; i < exp_bdi.size() && i < got_bdi.size(); i++) begin
            chk({name, " bdi data"}, got_bdi[i].data, exp_bdi[i].data);
            chk({name, " bdi type"}, got_bdi[i].typ, exp_bdi[i].typ);
            chk({name, " bdi eot/eoi"}, {got_bdi[i].eot, got_bdi[i].eoi},
                {exp_bdi[i].eot, exp_bdi[i].eoi});
        end
        chk({name, " key count"}, 64'(got_key.size()), 64'(exp_key.size()));
        for (int i = 0; i < exp_key.size() && i < got_key.size(); i++)
            chk({name, " key data"}, got_key[i], exp_key[i]);
        got_bdi.delete(); exp_bdi.delete(); got_key.delete(); exp_key.delete();
    endtask

    task automatic readback(input string name, input int n);
        logic [31:0] r;
        logic [31:0] e;
        spi_begin();
        for (int i = 0; i < n; i++) begin
            spi_bits(32'hFFFF_FFFF, 32, r);
            e = (exp_fifo.size() != 0) ? exp_fifo.pop_front() : 32'h0;
            chk({name, " miso word"}, r, e);
        end
        spi_end();
    endtask

    task automatic push_bdo(input logic [31:0] w);
        @(posedge clk);
        #1 bdo = w; bdo_valid = 1'b1;
        @(posedge clk);
        #1 bdo_valid = 1'b0; bdo = '0;
        exp_fifo.push_back(w);
    endtask

    vec_t vecs[10];
    logic [31:0] w0, w1, r;
    logic [3:0] rop;

    initial begin
        vecs[0] = '{{OP_DO_ENC, 28'h0},                1'b0, 1'b0, 0};
        vecs[1] = '{{OP_DO_DEC, 28'h0},                1'b1, 1'b0, 0};
        vecs[2] = '{{OP_DO_HASH, 28'h0},               1'b0, 1'b1, 0};
        vecs[3] = '{{4'hF, 4'h0, 24'd8},               1'b0, 1'b1, 0};
        vecs[4] = '{{OP_LD_AD, 4'h1, 24'd0},           1'b0, 1'b1, 0};
        vecs[5] = '{{OP_DO_DEC, 28'h0},                1'b1, 1'b0, 0};
        vecs[6] = '{{OP_LD_NONCE, 4'h1, 24'd16},       1'b1, 1'b0, 4};
        vecs[7] = '{{OP_LD_CT, 4'h0, 24'd3},           1'b1, 1'b0, 1};
        vecs[8] = '{{OP_LD_TAG, 4'h1, 24'd13},         1'b1, 1'b0, 4};
        vecs[9] = '{{OP_LD_KEY, 4'h0, 24'd1},          1'b1, 1'b0, 1};

        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset flags", {key_valid, bdi_valid, bdi_eot, bdi_eoi, decrypt, hash, ovf, spi_miso}, 0);
        chk("reset bdi_type", bdi_type, D_NULL);
        chk("reset data", {key, bdi}, 0);
        chk("reset readies", {bdo_ready, auth_ready}, 2'b11);

        // key load then back to instruction decoding
        run_load(OP_LD_KEY, 4'h0, 24'h10);
        check_streams("key load");
        run_do(OP_DO_DEC);
        chk("after key DO_DEC mode", {decrypt, hash}, 2'b10);

        // plaintext segment
        run_do(OP_DO_ENC);
        chk("DO_ENC mode", {decrypt, hash}, 2'b00);
        run_load(OP_LD_PT, 4'h1, 24'd5);
        check_streams("pt segment");
        chk("pt decrypt", decrypt, 1'b0);

        // backpressure: second word dropped, sticky overflow
        @(posedge clk); #1 bdi_ready = 1'b0;
        w0 = $urandom; w1 = $urandom;
        send_word({OP_LD_AD, 4'h0, 24'd8});
        send_word(w0);
        send_word(w1);
        @(negedge clk);
        chk("bp bdi_valid", bdi_valid, 1'b1);
        chk("bp held word", bdi, w0);
        chk("bp ovf", ovf, 1'b1);
        chk("bp no handshake", 64'(got_bdi.size()), 0);
        @(posedge clk); #1 bdi_ready = 1'b1;
        repeat (10) @(posedge clk);
        exp_bdi.push_back('{w0, D_AD, 1'b0, 1'b0});
        check_streams("backpressure");
        chk("bp ovf still set", ovf, 1'b1);
        do_reset();
        @(negedge clk);
        chk("ovf cleared by reset", ovf, 1'b0);

        // cs_n abort in mid-word
        send_word({OP_LD_AD, 4'h1, 24'd4});
        spi_begin(); spi_bits(32'hAAAA_AAAA, 17, r); spi_end();
        w0 = $urandom;
        send_word(w0);
        exp_bdi.push_back('{w0, D_AD, 1'b1, 1'b1});
        check_streams("abort data");
        spi_begin(); spi_bits(32'h5555_5555, 17, r); spi_end();
        run_do(OP_DO_HASH);
        chk("abort then DO_HASH mode", {decrypt, hash}, 2'b01);
        chk("abort ovf", ovf, 1'b0);

        // readback with bdo/auth same-cycle contention
        @(posedge clk);
        #1 bdo = 32'hDEAD_BEEF; bdo_valid = 1'b1; auth = 1'b1; auth_valid = 1'b1;
        @(negedge clk);
        chk("contention auth_ready", auth_ready, 1'b0);
        @(posedge clk); #1 bdo_valid = 1'b0; bdo = '0;
        @(posedge clk); #1 auth_valid = 1'b0; auth = 1'b0;
        exp_fifo.push_back(32'hDEAD_BEEF);
        exp_fifo.push_back(32'h0000_0001);
        readback("readback", 3);

        // fill the FIFO, hold a word against a full FIFO, drain
        for (int i = 0; i < 4; i++) push_bdo($urandom);
        @(negedge clk);
        chk("full bdo_ready", bdo_ready, 1'b0);
        chk("full auth_ready", auth_ready, 1'b0);
        @(posedge clk); #1 bdo = 32'h1234_5678; bdo_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 bdo_valid = 1'b0; bdo = '0;
        readback("full drain", 5);

        // reset in the middle of a data segment
        @(posedge clk); #1 bdi_ready = 1'b0;
        send_word({OP_LD_NONCE, 4'h0, 24'd8});
        send_word($urandom);
        push_bdo(32'h0000_0055);
        @(negedge clk);
        chk("pre-reset bdi_valid", bdi_valid, 1'b1);
        do_reset();
        @(negedge clk);
        chk("mid reset flags", {key_valid, bdi_valid, bdi_eot, bdi_eoi, decrypt, hash, ovf, spi_miso}, 0);
        chk("mid reset bdi_type", bdi_type, D_NULL);
        chk("mid reset data", {key, bdi}, 0);
        @(posedge clk); #1 bdi_ready = 1'b1;
        readback("post reset fifo", 1);
        run_do(OP_DO_DEC);
        chk("post reset DO_DEC mode", {decrypt, hash}, 2'b10);
        check_streams("post reset");

        // instruction table
        for (int v = 0; v < 10; v++) begin
            send_word(vecs[v].ins);
            for (int i = 0; i < vecs[v].exp_words; i++) begin
                w0 = $urandom;
                if (vecs[v].ins[31:28] == OP_LD_KEY)
                    exp_key.push_back(w0);
                else
                    exp_bdi.push_back('{w0, type_of(vecs[v].ins[31:28]),
                                        i == vecs[v].exp_words - 1,
                                        (i == vecs[v].exp_words - 1) && vecs[v].ins[24]});
                send_word(w0);
            end
            check_streams("table");
            chk("table mode", {decrypt, hash}, {vecs[v].exp_dec, vecs[v].exp_hash});
        end
        model_dec = 1'b1; model_hash = 1'b0;

        // randomized instruction stream against the model
        for (int it = 0; it < 20; it++) begin
            rop = 4'($urandom_range(0, 9));
            if (rop == 4'd9) rop = 4'hF;
            if (rop <= OP_DO_HASH)
                run_do(rop);
            else if (rop == 4'hF)
                send_word({rop, 28'($urandom)});
            else
                run_load(rop, 4'($urandom), 24'($urandom_range(0, 16)));
            check_streams("random");
            chk("random mode", {decrypt, hash}, {model_dec, model_hash});
        end

        for (int it = 0; it < 3; it++) begin
            int k;
            k = $urandom_range(1, 4);
            for (int i = 0; i < k; i++) push_bdo($urandom);
            readback("random readback", k + 1);
        end
        chk("final ovf", ovf, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
